rr_sel_arbiter8: RTL and testbench

Round-robin arbiter for 8 requesters that sits directly upstream of the 3-to-8 one-hot decoder. It produces a registered 3-bit grant index plus a valid flag. The decoder turns the index into a one-hot grant bus, and downstream gating uses grant_valid_out. The block owns fairness rotation, grant hold/release handshake and a hold-time watchdog.

---
 rtl/rr_sel_arbiter8_pkg.sv | 20 ++
 rtl/rr_sel_arbiter8_if.sv | 38 +++
 rtl/rr_sel_arbiter8_pick8.sv | 44 ++++
 rtl/rr_sel_arbiter8.sv | 114 +++++++++++
 tb/tb_rr_sel_arbiter8.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_sel_arbiter8_pkg.sv
// -----------------------------------------------------------------------------
// rr_sel_arbiter8_pkg
// Shared constants and types for the 8-way round-robin grant-index arbiter.
//   NUM_REQ : number of requesters
//   IDX_W   : width of a requester index (grant_idx_out, pointer)
//   HOLD_W  : width of the saturating grant-hold counter
//   state_e : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package rr_sel_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage : rr_sel_arbiter8_pkg

// File: rtl/rr_sel_arbiter8_if.sv
// -----------------------------------------------------------------------------
// rr_sel_arbiter8_if
// Request/grant bundle between the requesters and the arbiter.
//   req_in          : request vector, bit i = requester i
//   done_in         : current owner releases its grant
//   grant_idx_out   : index of the granted requester (to the 3-to-8 decoder)
//   grant_valid_out : grant_idx_out is a live grant
//   timeout_out     : one-cycle pulse, grant was force-released by the watchdog
// Modports:
//   slave  : the arbiter side (consumes requests, drives grants)
//   master : the requester/system side (drives requests, observes grants)
// -----------------------------------------------------------------------------
interface rr_sel_arbiter8_if;
    import rr_sel_arbiter8_pkg::*;

    logic [NUM_REQ-1:0] req_in;
    logic               done_in;
    logic [IDX_W-1:0]   grant_idx_out;
    logic               grant_valid_out;
    logic               timeout_out;

    modport slave (
        input  req_in,
        input  done_in,
        output grant_idx_out,
        output grant_valid_out,
        output timeout_out
    );

    modport master (
        output req_in,
        output done_in,
        input  grant_idx_out,
        input  grant_valid_out,
        input  timeout_out
    );

endinterface : rr_sel_arbiter8_if

// File: rtl/rr_sel_arbiter8_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational rotate-priority picker. Returns the first set request bit found
// scanning upward from ptr, wrapping from 7 back to 0.
//   req : request vector
//   ptr : index with highest priority this round
//   idx : winning requester index (meaningful only when any=1)
//   any : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick8
    import rr_sel_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     pos;

    // Rotating the doubled vector right by ptr puts requester ptr at bit 0,
    // so a plain LSB-first search implements the wrapping scan.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    // NOTE: combinational logic uses blocking '=' so each loop iteration sees
    // the previous one's result; clocked state uses '<=' instead.
    always_comb begin
        pos = '0;
        // Walk downward so the lowest set bit is the last (winning) write.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

    // Undo the rotation; the IDX_W-bit add wraps modulo 8 for free.
    assign idx = pos + ptr;
    assign any = |req;

endmodule : rr_pick8

// File: rtl/rr_sel_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_sel_arbiter8
// Round-robin arbiter for 8 requesters producing a registered grant index and
// valid flag for a downstream 3-to-8 one-hot decoder. Grants are held until the
// owner signals done, drops its request, or the hold-time watchdog fires. Every
// grant is followed by at least one invalid cycle (break-before-make on the
// decoded bus), and the pointer moves past the last owner so it is served last
// if it re-requests while others are waiting.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : request/grant bundle (slave modport)
// Parameter:
//   MAX_HOLD : max consecutive grant cycles before forced release (0..255),
//              0 disables the watchdog
// -----------------------------------------------------------------------------
module rr_sel_arbiter8
    import rr_sel_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    rr_sel_arbiter8_if.slave     bus
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic              WD_EN      = (MAX_HOLD != 0);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              timeout_q, timeout_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              rel_done;
    logic              rel_drop;
    logic              rel_wd;
    logic              release_now;

    rr_pick8 u_pick (
        .req (bus.req_in),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Release causes while granted. Only the owner's request bit matters;
    // other requesters changing their bits mid-grant have no effect.
    assign rel_done    = bus.done_in;
    assign rel_drop    = ~bus.req_in[idx_q];
    assign rel_wd      = WD_EN && (hold_q == MAX_HOLD_C);
    assign release_now = rel_done | rel_drop | rel_wd;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    idx_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                end
            end

            ST_GRANT: begin
                if (release_now) begin
                    state_d   = ST_IDLE;
                    ptr_d     = idx_q + IDX_W'(1);
                    hold_d    = '0;
                    // Owner-initiated release wins over the watchdog: no pulse.
                    timeout_d = rel_wd & ~rel_done & ~rel_drop;
                end else if (hold_q != {HOLD_W{1'b1}}) begin
                    // Saturation only matters with the watchdog disabled.
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
        end
    end

    // All outputs come straight from flops; grant_valid_out is the state bit.
    assign bus.grant_idx_out   = idx_q;
    assign bus.grant_valid_out = (state_q == ST_GRANT);
    assign bus.timeout_out     = timeout_q;

endmodule : rr_sel_arbiter8

// File: tb/tb_rr_sel_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_sel_arbiter8
// Scoreboard bench for rr_sel_arbiter8 (MAX_HOLD=4). The stimulus process
// drives inputs on the falling edge, advances a behavioural model of the
// arbitration rules and queues the outputs expected after the next rising
// edge; an independent monitor pops and compares just after each rising edge.
// -----------------------------------------------------------------------------
module tb_rr_sel_arbiter8;
    import rr_sel_arbiter8_pkg::*;

    localparam int unsigned MAX_HOLD = 4;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic       timeout;
    } resp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_sel_arbiter8_if bus_if ();

    rr_sel_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Behavioural model state: who owns the grant (or nobody), where the
    // rotation starts next, and how many cycles the current grant has lasted.
    bit m_granted;
    int m_owner;
    int m_next_first;
    int m_cycles;
    bit m_timeout;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_step(input bit r, input logic [7:0] req, input bit done);
        m_timeout = 1'b0;
        if (r) begin
            m_granted    = 1'b0;
            m_owner      = 0;
            m_next_first = 0;
            m_cycles     = 0;
        end else if (!m_granted) begin
            for (int k = 0; k < 8; k++) begin
                if (req[(m_next_first + k) % 8]) begin
                    m_granted = 1'b1;
                    m_owner   = (m_next_first + k) % 8;
                    m_cycles  = 1;
                    break;
                end
            end
        end else begin
            bit by_owner;
            bit by_watchdog;
            by_owner    = done || !req[m_owner];
            by_watchdog = (MAX_HOLD != 0) && (m_cycles == int'(MAX_HOLD));
            if (by_owner || by_watchdog) begin
                m_granted    = 1'b0;
                m_next_first = (m_owner + 1) % 8;
                m_cycles     = 0;
                m_timeout    = by_watchdog && !by_owner;
            end else if (m_cycles < 255) begin
                m_cycles++;
            end
        end
    endfunction

    // One clock of stimulus: apply inputs, queue the expected response.
    task automatic cycle(input bit r, input logic [7:0] req, input bit done);
        rst            = r;
        bus_if.req_in  = req;
        bus_if.done_in = done;
        model_step(r, req, done);
        exp_q.push_back(resp_t'{valid: m_granted, idx: 3'(m_owner), timeout: m_timeout});
        @(negedge clk);
    endtask

    // Monitor: outputs are live every cycle, so one queue entry per edge.
    initial begin
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("grant_valid", 32'(bus_if.grant_valid_out), 32'(e.valid));
                check("grant_idx",   32'(bus_if.grant_idx_out),   32'(e.idx));
                check("timeout",     32'(bus_if.timeout_out),     32'(e.timeout));
            end
        end
    end

    initial begin
        logic [7:0] rq;

        // Reset.
        cycle(1, 8'h00, 0);
        cycle(1, 8'hFF, 1);
        cycle(0, 8'h00, 1);

        // Basic grant/release; then pointer 3 must beat requester 2.
        cycle(0, 8'h04, 0);
        cycle(0, 8'h04, 0);
        cycle(0, 8'h04, 0);
        cycle(0, 8'h04, 1);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h0C, 0);
        cycle(0, 8'h0C, 1);
        cycle(0, 8'h00, 0);

        // Rotation fairness from pointer 0 with everyone requesting.
        cycle(1, 8'h00, 0);
        cycle(0, 8'hFF, 0);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 8'hFF, 1);
            cycle(0, 8'hFF, 0);
        end

        // Wrap-around: grant 5, then 0 and 1 from pointer 6.
        cycle(1, 8'h00, 0);
        cycle(0, 8'h20, 0);
        cycle(0, 8'h20, 1);
        cycle(0, 8'h03, 0);
        cycle(0, 8'h03, 1);
        cycle(0, 8'h03, 0);
        cycle(0, 8'h03, 1);
        cycle(0, 8'h00, 0);

        // Watchdog: requester 4 holds its request and never says done.
        for (int i = 0; i < 14; i++) cycle(0, 8'h10, 0);
        cycle(0, 8'h00, 0);

        // Precedence 1: done in the 4th grant cycle, no timeout pulse.
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 1);
        cycle(0, 8'h00, 0);

        // Precedence 2: owner drops its bit in grant cycle 2.
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);

        // Precedence 3: drop at the watchdog limit, no timeout pulse.
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 0);
        cycle(0, 8'h10, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);

        // Reset mid-grant of idx 6, then 8'hC0 must grant 6 from pointer 0.
        cycle(1, 8'h00, 0);
        cycle(0, 8'h80, 0);
        cycle(0, 8'h80, 1);
        cycle(0, 8'h40, 0);
        cycle(0, 8'h40, 0);
        cycle(1, 8'h40, 0);
        cycle(0, 8'hC0, 0);
        cycle(0, 8'hC0, 0);
        cycle(0, 8'hC0, 1);
        cycle(0, 8'hC0, 0);
        cycle(0, 8'h00, 0);

        // Randomized traffic: requests mostly held for several cycles so the
        // watchdog fires, with sporadic done pulses and rare resets.
        rq = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) rq = 8'($urandom);
            if ($urandom_range(15) == 0) rq = 8'h00;
            cycle($urandom_range(199) == 0, rq, $urandom_range(5) == 0);
        end

        // Every queued expectation must have been consumed by the monitor.
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_sel_arbiter8
